uart_receiver: RTL and testbench
================================

# uart_receiver

Serial receive half of the UART link: recovers 8-bit frames from the `RxD` line and presents them as `Rx_DATA`, with a one-cycle `Rx_VALID` strobe and error flags. It uses 16x oversampling from a shared baud tick generator with a 3-bit baud select. It sits opposite the transmitter inside `uart_system` and feeds the 7-segment display path.

## Interface
- `CLK_HZ`, default 50_000_000: system clock frequency, used to derive the 16x tick divisors.
- `clk` input 1: system clock, 20 ns period nominal.
- `reset` input 1: asynchronous, active-low reset.
- `baud_select` input 3: rate select. 000=300, 001=1200, 010=4800, 011=9600, 100=19200, 101=38400, 110=57600, 111=115200 baud.
- `Rx_EN` input 1: receiver enable.
- `RxD` input 1: serial line, idle high, asynchronous to `clk`.
- `Rx_DATA` output 8: last good byte, LSB received first.
- `Rx_VALID` output 1: one-cycle strobe for a good frame.
- `Rx_FERROR` output 1: framing error flag (stop bit sampled 0).
- `Rx_PERROR` output 1: even-parity mismatch flag.

## Operation
- Frame format: start(0), D0..D7, even parity, stop(1). Total 11 bits, 16 ticks per bit.
- `RxD` passes through a 2-flop synchronizer. All decisions use the synchronized value.
- Tick divisor = round(CLK_HZ/(16*baud)). At 50 MHz: 10417, 2604, 651, 326, 163, 81, 54, 27.
- Tick counter: 14 bits, restarts whenever `baud_select` changes.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: armed only after seeing `RxD`=1 on at least one tick. On an armed tick with `RxD`=0, go to START and clear tick count.
  - START: at tick 8, if the line is still 0, go to DATA. Otherwise it is a glitch: return to IDLE with no flag change.
  - DATA: sample every 16 ticks (mid-bit), shifting in LSB first. After D7, go to PARITY.
  - PARITY: sample the parity bit and compare with the XOR of the data. Go to STOP.
  - STOP: sample mid-bit, then return to IDLE immediately.
- Stop sample results:
  - Stop=1 and parity OK: load `Rx_DATA` and pulse `Rx_VALID`.
  - Stop=0: set `Rx_FERROR`.
  - Parity mismatch: set `Rx_PERROR`.
  - Both errors: set both flags, no `Rx_VALID`, `Rx_DATA` unchanged.
- Flags hold until the next START entry, which clears both.
- `Rx_EN`=0: FSM forced to IDLE (disarmed) and any frame in progress is dropped. Outputs hold.
- Break condition (line held low): one FERROR frame, then no further frames until the line returns high.

## Timing
- Reset values: `Rx_DATA`=0x00, `Rx_VALID`=0, `Rx_FERROR`=0, `Rx_PERROR`=0, FSM in IDLE (disarmed).
- Latency: `Rx_VALID`/flags are registered 1 clk after the tick on which the stop bit is sampled.
  - The stop sample falls 168 ticks after start detection, plus up to 1 tick of detection jitter, plus 2 clk of synchronizer delay.
  - At 115200 baud / 50 MHz: about 4536 + 3 clk after the falling edge.
- `Rx_VALID` is exactly one `clk` wide. `Rx_DATA` is stable from the `Rx_VALID` cycle until the next good frame.
- Back-to-back frames are accepted, because the FSM re-enters IDLE half a bit before the stop bit ends.
- Reset asserted mid-frame: all outputs go to their reset values immediately (asynchronous).

## Configuration
- `UART_RX_PARITY_EN`:
  - Defined: 11-bit frame with PARITY state and parity checking.
  - Undefined: 10-bit frame, PARITY state removed, `Rx_PERROR` tied 0, and the stop sample falls at tick 152 after start detection.

## Structure
- Package `uart_pkg`: baud divisor constants per `baud_select`, FSM state encoding, frame length and oversample constants. Shared with the transmitter.
- Sub-module `baud_controller`: divider emitting a one-clk `Rx_sample_ENABLE` tick at 16x baud. The same module serves the transmitter.

## Test plan
- 115200 baud, send 0xAA with parity 0 and stop 1 -> `Rx_DATA`=0xAA, single `Rx_VALID` pulse about 4539 clk after the start edge, both flags 0.
- Send 0x68 with parity 1, then immediately 0x55 with parity 0 -> two `Rx_VALID` pulses, `Rx_DATA` 0x68 then 0x55.
- Send 0x68 with parity 0 -> `Rx_PERROR`=1, no `Rx_VALID`, `Rx_DATA` keeps its previous value. The next good frame clears `Rx_PERROR`.
- Send 0xAA with stop bit 0, then hold the line low for 3 frames -> one `Rx_FERROR`=1 and no further frames until the line returns high.
- 9600 baud, low glitch of 4 ticks (1304 clk) -> no state change, no strobe. Then a valid frame 0x3C -> received correctly.
- Drop `Rx_EN` after D3 of a frame -> no `Rx_VALID` or flags for that frame. Re-enable and send 0x81 -> received. Assert `reset` mid-frame -> all outputs 0 within the same cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, FSM state encoding and baud divisors.
// UART_RX_PARITY_EN adds the PARITY state (11-bit frame).
package uart_pkg;

   localparam int OVERSAMPLE = 16;
   localparam int TICK_W     = 14;
   localparam int DATA_BITS  = 8;
   localparam int MID_TICK   = 7;

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP
   } rx_state_t;
`else
   typedef enum logic [2:0] {
      IDLE, START, DATA, STOP
   } rx_state_t;
`endif

   function automatic int unsigned baud_rate(input logic [2:0] sel);
      case (sel)
         3'd0:    return 300;
         3'd1:    return 1200;
         3'd2:    return 4800;
         3'd3:    return 9600;
         3'd4:    return 19200;
         3'd5:    return 38400;
         3'd6:    return 57600;
         default: return 115200;
      endcase
   endfunction

   // Rounded clk_hz / (16 * baud)
   function automatic logic [TICK_W-1:0] baud_div(
      input int unsigned clk_hz,
      input logic [2:0]  sel
   );
      int unsigned den;
      den = OVERSAMPLE * baud_rate(sel);
      return TICK_W'((clk_hz + den / 2) / den);
   endfunction

endpackage

// File: rtl/baud_controller.sv
// baud_controller: 16x oversample tick divider, one-clk Rx_sample_ENABLE.
// Counter restarts whenever baud_select changes.
module baud_controller
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ = 50_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] baud_select,
   output logic       Rx_sample_ENABLE
);

   localparam logic [TICK_W-1:0] DIV [8] = '{
      baud_div(CLK_HZ, 3'd0), baud_div(CLK_HZ, 3'd1),
      baud_div(CLK_HZ, 3'd2), baud_div(CLK_HZ, 3'd3),
      baud_div(CLK_HZ, 3'd4), baud_div(CLK_HZ, 3'd5),
      baud_div(CLK_HZ, 3'd6), baud_div(CLK_HZ, 3'd7)
   };

   logic [TICK_W-1:0] cnt;
   logic [TICK_W-1:0] div;
   logic [2:0]        sel_q;

   assign div = DIV[baud_select];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt              <= '0;
         sel_q            <= '0;
         Rx_sample_ENABLE <= 1'b0;
      end else begin
         sel_q            <= baud_select;
         Rx_sample_ENABLE <= 1'b0;
         if (sel_q != baud_select) begin
            cnt <= '0;
         end else if (cnt == div - 1'b1) begin
            cnt              <= '0;
            Rx_sample_ENABLE <= 1'b1;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 16x oversampled 8-bit UART receive path with error flags.
// UART_RX_PARITY_EN enables the even-parity bit and Rx_PERROR.
module uart_receiver
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ = 50_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] baud_select,
   input  logic       Rx_EN,
   input  logic       RxD,
   output logic [7:0] Rx_DATA,
   output logic       Rx_VALID,
   output logic       Rx_FERROR,
   output logic       Rx_PERROR
);

   rx_state_t state, state_n;

   logic       rx_q1, rx_s, tick, mid;
   logic       armed, armed_n;
   logic [3:0] cnt, cnt_n;
   logic [2:0] bit_idx, bit_n;
   logic [7:0] shift, shift_n, data_n;
   logic       par_bad, par_bad_n;
   logic       valid_n, ferr_n, perr_n;

   baud_controller #(.CLK_HZ(CLK_HZ)) u_baud (
      .clk              (clk),
      .reset            (reset),
      .baud_select      (baud_select),
      .Rx_sample_ENABLE (tick)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_q1 <= 1'b1;
         rx_s  <= 1'b1;
      end else begin
         rx_q1 <= RxD;
         rx_s  <= rx_q1;
      end
   end

   // cnt is zeroed on start detection, so every mid-bit lands on cnt==7
   assign mid = tick && (cnt == 4'(MID_TICK));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         armed     <= 1'b0;
         cnt       <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         par_bad   <= 1'b0;
         Rx_DATA   <= '0;
         Rx_VALID  <= 1'b0;
         Rx_FERROR <= 1'b0;
         Rx_PERROR <= 1'b0;
      end else begin
         state     <= state_n;
         armed     <= armed_n;
         cnt       <= cnt_n;
         bit_idx   <= bit_n;
         shift     <= shift_n;
         par_bad   <= par_bad_n;
         Rx_DATA   <= data_n;
         Rx_VALID  <= valid_n;
         Rx_FERROR <= ferr_n;
         Rx_PERROR <= perr_n;
      end
   end

   always_comb begin
      state_n   = state;
      armed_n   = armed;
      cnt_n     = cnt;
      bit_n     = bit_idx;
      shift_n   = shift;
      par_bad_n = par_bad;
      data_n    = Rx_DATA;
      valid_n   = 1'b0;
      ferr_n    = Rx_FERROR;
      perr_n    = Rx_PERROR;
      if (tick)
         cnt_n = cnt + 4'd1;
      if (!Rx_EN) begin
         state_n = IDLE;
         armed_n = 1'b0;
      end else begin
         unique case (state)
            IDLE: if (tick) begin
               if (rx_s) begin
                  armed_n = 1'b1;
               end else if (armed) begin
                  state_n = START;
                  armed_n = 1'b0;
                  cnt_n   = '0;
                  ferr_n  = 1'b0;
                  perr_n  = 1'b0;
               end
            end
            START: if (mid) begin
               if (!rx_s) begin
                  state_n   = DATA;
                  bit_n     = '0;
                  par_bad_n = 1'b0;
               end else begin
                  state_n = IDLE;
               end
            end
            DATA: if (mid) begin
               shift_n = {rx_s, shift[7:1]};
               bit_n   = bit_idx + 3'd1;
               if (bit_idx == 3'(DATA_BITS - 1))
`ifdef UART_RX_PARITY_EN
                  state_n = PARITY;
`else
                  state_n = STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (mid) begin
               par_bad_n = rx_s ^ (^shift);
               state_n   = STOP;
            end
`endif
            STOP: if (mid) begin
               state_n = IDLE;
               ferr_n  = !rx_s;
               perr_n  = par_bad;
               if (rx_s && !par_bad) begin
                  data_n  = shift;
                  valid_n = 1'b1;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames against uart_receiver, both frame formats.
// Bench clock is 25 MHz: divisor 14 at 115200, 163 at 9600.
`timescale 1ns/1ps
module tb_uart_receiver;

`ifdef UART_RX_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif
   localparam int unsigned CLK_HZ = 25_000_000;
   localparam int B_FAST     = 16 * 14;
   localparam int B_SLOW     = 16 * 163;
   localparam int NBITS      = PAR ? 11 : 10;
   localparam int STOP_TICKS = PAR ? 168 : 152;
   localparam int LAT_LO     = STOP_TICKS * 14;
   localparam int LAT_HI     = STOP_TICKS * 14 + 20;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [2:0] baud_select = 3'b111;
   logic       Rx_EN = 1'b0;
   logic       RxD = 1'b1;
   logic [7:0] Rx_DATA;
   logic       Rx_VALID;
   logic       Rx_FERROR;
   logic       Rx_PERROR;

   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   int         vcnt = 0;
   int         first_v = -1;
   int         t0 = 0;
   logic [7:0] vdata[$];

   uart_receiver #(.CLK_HZ(CLK_HZ)) dut (
      .clk         (clk),
      .reset       (reset),
      .baud_select (baud_select),
      .Rx_EN       (Rx_EN),
      .RxD         (RxD),
      .Rx_DATA     (Rx_DATA),
      .Rx_VALID    (Rx_VALID),
      .Rx_FERROR   (Rx_FERROR),
      .Rx_PERROR   (Rx_PERROR)
   );

   always #20 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (Rx_VALID) begin
         vcnt++;
         vdata.push_back(Rx_DATA);
         if (first_v < 0)
            first_v = cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clr();
      vcnt    = 0;
      first_v = -1;
      vdata.delete();
   endtask

   task automatic wait_bits(input int n, input int bt);
      repeat (n * bt) @(negedge clk);
   endtask

   // Drives the first nb bits of a frame; line is left at the last bit
   task automatic send(input logic [7:0] d, input logic p, input logic s,
                       input int bt, input int nb);
      logic [10:0] f;
      f = PAR ? {s, p, d, 1'b0} : {1'b0, s, d, 1'b0};
      for (int i = 0; i < NBITS && i < nb; i++) begin
         RxD = f[i];
         repeat (bt) @(negedge clk);
      end
   endtask

   function automatic logic [7:0] vd(input int i);
      return (vdata.size() > i) ? vdata[i] : 8'hxx;
   endfunction

   initial begin
      int lat;
      repeat (3) @(negedge clk);
      chk("rst_data", Rx_DATA, 8'h00);
      chk("rst_valid", Rx_VALID, 1'b0);
      chk("rst_ferr", Rx_FERROR, 1'b0);
      chk("rst_perr", Rx_PERROR, 1'b0);

      reset = 1'b1;
      Rx_EN = 1'b1;
      wait_bits(2, B_FAST);

      clr();
      t0 = cyc;
      send(8'hAA, 1'b0, 1'b1, B_FAST, 11);
      RxD = 1'b1;
      wait_bits(1, B_FAST);
      lat = first_v - t0;
      chk("aa_cnt", vcnt, 1);
      chk("aa_data", Rx_DATA, 8'hAA);
      chk("aa_ferr", Rx_FERROR, 1'b0);
      chk("aa_perr", Rx_PERROR, 1'b0);
      chk("aa_lat", (lat >= LAT_LO && lat <= LAT_HI), 1'b1);

      clr();
      send(8'h68, 1'b0, 1'b1, B_FAST, 11);
      RxD = 1'b1;
      wait_bits(1, B_FAST);
      chk("pe_cnt", vcnt, PAR ? 0 : 1);
      chk("pe_perr", Rx_PERROR, PAR);
      chk("pe_data", Rx_DATA, PAR ? 8'hAA : 8'h68);
      chk("pe_ferr", Rx_FERROR, 1'b0);

      clr();
      send(8'h68, 1'b1, 1'b1, B_FAST, 11);
      send(8'h55, 1'b0, 1'b1, B_FAST, 11);
      RxD = 1'b1;
      wait_bits(1, B_FAST);
      chk("b2b_cnt", vcnt, 2);
      chk("b2b_d0", vd(0), 8'h68);
      chk("b2b_d1", vd(1), 8'h55);
      chk("b2b_perr", Rx_PERROR, 1'b0);
      chk("b2b_ferr", Rx_FERROR, 1'b0);

      clr();
      send(8'hAA, 1'b0, 1'b0, B_FAST, 11);
      RxD = 1'b0;
      wait_bits(3 * NBITS, B_FAST);
      chk("brk_cnt", vcnt, 0);
      chk("brk_ferr", Rx_FERROR, 1'b1);
      chk("brk_perr", Rx_PERROR, 1'b0);
      RxD = 1'b1;
      wait_bits(2, B_FAST);
      chk("brk_quiet", vcnt, 0);

      baud_select = 3'b011;
      wait_bits(1, B_SLOW);
      clr();
      RxD = 1'b0;
      repeat (4 * 163) @(negedge clk);
      RxD = 1'b1;
      wait_bits(1, B_SLOW);
      chk("gl_cnt", vcnt, 0);
      chk("gl_data", Rx_DATA, 8'h55);
      send(8'h3C, 1'b0, 1'b1, B_SLOW, 11);
      RxD = 1'b1;
      wait_bits(1, B_SLOW);
      chk("s_cnt", vcnt, 1);
      chk("s_data", Rx_DATA, 8'h3C);
      chk("s_ferr", Rx_FERROR, 1'b0);
      chk("s_perr", Rx_PERROR, 1'b0);

      baud_select = 3'b111;
      wait_bits(2, B_FAST);
      clr();
      send(8'hF0, 1'b1, 1'b0, B_FAST, 5);
      Rx_EN = 1'b0;
      RxD = 1'b0;
      wait_bits(7, B_FAST);
      RxD = 1'b1;
      wait_bits(2, B_FAST);
      chk("en_cnt", vcnt, 0);
      chk("en_ferr", Rx_FERROR, 1'b0);
      chk("en_perr", Rx_PERROR, 1'b0);
      chk("en_data", Rx_DATA, 8'h3C);
      Rx_EN = 1'b1;
      wait_bits(2, B_FAST);
      send(8'h81, 1'b0, 1'b1, B_FAST, 11);
      RxD = 1'b1;
      wait_bits(1, B_FAST);
      chk("re_cnt", vcnt, 1);
      chk("re_data", Rx_DATA, 8'h81);
      chk("re_ferr", Rx_FERROR, 1'b0);
      chk("re_perr", Rx_PERROR, 1'b0);

      clr();
      send(8'h7E, 1'b0, 1'b1, B_FAST, 4);
      reset = 1'b0;
      #1;
      chk("mr_data", Rx_DATA, 8'h00);
      chk("mr_valid", Rx_VALID, 1'b0);
      chk("mr_ferr", Rx_FERROR, 1'b0);
      chk("mr_perr", Rx_PERROR, 1'b0);
      RxD = 1'b1;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      repeat (5) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
